// File: rtl/distance_pkg.sv
// Shared definitions for the distance filter and the display/control logic
// that consumes its outputs.
package distance_pkg;

    localparam int DIST_W        = 16;
    localparam int MAX_VALID_DEF = 400;
    localparam int NEAR_ON_DEF   = 20;
    localparam int NEAR_OFF_DEF  = 25;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/distance_ring.sv
// Sample window storage: one write port and a combinational read at the
// write pointer, so the oldest entry is available as it is overwritten.
module distance_ring
    import distance_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_ptr,
    input  logic [DIST_W-1:0]     wr_data,
    output logic [DIST_W-1:0]     rd_data
);

    logic [DIST_W-1:0] mem [1<<DEPTH_LOG2];

    // No reset: an entry is only read for subtraction once it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/distance_filter.sv
// Range-checks ranging results, keeps a moving average over the last
// 2^DEPTH_LOG2 accepted samples, drives a hysteretic proximity flag and a timeout fault.
module distance_filter
    import distance_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int MAX_VALID  = MAX_VALID_DEF,
    parameter int NEAR_ON    = NEAR_ON_DEF,
    parameter int NEAR_OFF   = NEAR_OFF_DEF,
    parameter int TIMEOUT    = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done_in,
    input  logic [DIST_W-1:0] distance_in,
    output logic [DIST_W-1:0] avg_distance,
    output logic              avg_valid,
    output logic              near,
    output logic              sample_rejected,
    output logic              fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = DIST_W + DEPTH_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t                state, next_state;
    logic                  done_q;
    logic [DIST_W-1:0]     sample_r;
    logic [SUM_W-1:0]      sum;
    logic [DEPTH_LOG2:0]   fill;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [DIST_W-1:0]     oldest;
    logic [DIST_W-1:0]     avg_next;
    logic                  edge_det;
    logic                  accept;
    logic                  full;
    logic                  wr_en;

    distance_ring #(.DEPTH_LOG2(DEPTH_LOG2)) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (sample_r),
        .rd_data (oldest)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        edge_det   = done_in & ~done_q;
        accept     = (sample_r != '0) && (sample_r <= DIST_W'(MAX_VALID));
        full       = (fill == (DEPTH_LOG2+1)'(DEPTH));
        wr_en      = (state == S_WRITE) && accept;
        avg_next   = DIST_W'(sum >> DEPTH_LOG2);
        case (state)
            S_IDLE:    if (edge_det) next_state = S_WRITE;
            S_WRITE:   next_state = accept ? S_PUBLISH : S_IDLE;
            S_PUBLISH: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q          <= 1'b0;
            sample_r        <= '0;
            sum             <= '0;
            fill            <= '0;
            wr_ptr          <= '0;
            tmo_cnt         <= '0;
            avg_distance    <= '0;
            avg_valid       <= 1'b0;
            near            <= 1'b0;
            sample_rejected <= 1'b0;
            fault           <= 1'b0;
        end else begin
            done_q          <= done_in;
            avg_valid       <= 1'b0;
            sample_rejected <= 1'b0;

            // Any accepted edge proves the sensor is alive, even if its reading is later rejected.
            if (state == S_IDLE && edge_det) begin
                sample_r <= distance_in;
                tmo_cnt  <= '0;
                fault    <= 1'b0;
            end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_W'(TIMEOUT - 1)) fault <= 1'b1;
            end

            if (state == S_WRITE) begin
                if (accept) begin
                    if (full) sum <= sum + SUM_W'(sample_r) - SUM_W'(oldest);
                    else      sum <= sum + SUM_W'(sample_r);
                    wr_ptr <= wr_ptr + 1'b1;
                    if (!full) fill <= fill + 1'b1;
                end else begin
                    sample_rejected <= 1'b1;
                end
            end

            if (state == S_PUBLISH && full && !fault) begin
                avg_distance <= avg_next;
                avg_valid    <= 1'b1;
                if (avg_next < DIST_W'(NEAR_ON))        near <= 1'b1;
                else if (avg_next >= DIST_W'(NEAR_OFF)) near <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: expected averages, flags and pulse timing
// are queued at stimulus time and checked by an independent output monitor.
module tb_distance_filter;

    localparam int TMO = 300;

    logic        clk;
    logic        reset;
    logic        done_in;
    logic [15:0] distance_in;
    logic [15:0] avg_distance;
    logic        avg_valid;
    logic        near;
    logic        sample_rejected;
    logic        fault;

    typedef struct {
        int          kind;   // 1 = average update, 2 = rejection
        logic [15:0] avg;
        logic        nr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   edge_cyc;

    distance_filter #(
        .DEPTH_LOG2 (3),
        .MAX_VALID  (400),
        .NEAR_ON    (20),
        .NEAR_OFF   (25),
        .TIMEOUT    (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .done_in         (done_in),
        .distance_in     (distance_in),
        .avg_distance    (avg_distance),
        .avg_valid       (avg_valid),
        .near            (near),
        .sample_rejected (sample_rejected),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset && (avg_valid || sample_rejected)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: avg_valid=%0b sample_rejected=%0b avg=%0d", avg_valid, sample_rejected, avg_distance);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", avg_valid ? 1 : 2, e.kind);
                check("pulse_both", int'(avg_valid & sample_rejected), 0);
                check("pulse_cycle", cyc, e.cyc);
                check("avg_distance", int'(avg_distance), int'(e.avg));
                if (e.kind == 1) check("near", int'(near), int'(e.nr));
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 = no output expected, 1 = average update, 2 = rejection
    task automatic send(input int d, input int kind, input int ea, input logic en);
        exp_t e;
        @(posedge clk);
        #1;
        done_in     = 1'b1;
        distance_in = 16'(d);
        edge_cyc    = cyc + 1;
        e.kind = kind;
        e.avg  = 16'(ea);
        e.nr   = en;
        e.cyc  = (kind == 1) ? edge_cyc + 2 : edge_cyc + 1;
        if (kind != 0) sb.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        done_in = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avg"},   int'(avg_distance), 0);
        check({tag, "_valid"}, int'(avg_valid), 0);
        check({tag, "_near"},  int'(near), 0);
        check({tag, "_rej"},   int'(sample_rejected), 0);
        check({tag, "_fault"}, int'(fault), 0);
    endtask

    int win_w[8] = '{20, 100, 20, 20, 20, 60, 5, 5};
    int win_a[8] = '{20, 30, 30, 30, 30, 35, 33, 31};
    int hy_x[6]  = '{10, 12, 44, 36, 28, 12};
    int hy_a[6]  = '{30, 19, 22, 24, 25, 19};
    int hy_n[6]  = '{0, 1, 1, 1, 0, 1};

    initial begin
        reset       = 1'b0;
        done_in     = 1'b0;
        distance_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        // Fill the window with 100s; only the eighth sample publishes.
        for (int i = 0; i < 7; i++) send(100, 0, 0, 1'b0);
        send(100, 1, 100, 1'b0);

        // Oldest 100 is replaced on each new 20.
        send(20, 1, 90, 1'b0);
        for (int i = 0; i < 8; i++) send(20, 1, (i < 7) ? 80 - 10 * i : 20, 1'b0);

        // Out-of-range readings leave the window untouched.
        send(0, 2, 20, 1'b0);
        send(500, 2, 20, 1'b0);
        send(401, 2, 20, 1'b0);
        send(400, 1, 67, 1'b0);
        // Window now seven 20s plus one 400 (sum 540); flush the 400 back out.
        for (int i = 0; i < 7; i++) send(20, 1, 67, 1'b0);
        send(20, 1, 20, 1'b0);

        // Build a window whose oldest entries allow averages 30,19,22,24,25,19.
        for (int i = 0; i < 8; i++) send(win_w[i], 1, win_a[i], 1'b0);
        for (int i = 0; i < 6; i++) send(hy_x[i], 1, hy_a[i], hy_n[i][0]);

        // Timeout: fault rises exactly TMO cycles after the last edge.
        wait_cyc(edge_cyc + TMO - 1);
        check("fault_early", int'(fault), 0);
        wait_cyc(edge_cyc + TMO);
        check("fault_set", int'(fault), 1);
        repeat (20) @(posedge clk);
        #1;
        check("fault_hold", int'(fault), 1);
        check("avg_hold_fault", int'(avg_distance), 19);
        check("near_hold_fault", int'(near), 1);
        // A rejected reading still proves the sensor alive.
        send(0, 2, 19, 1'b0);
        check("fault_clear", int'(fault), 0);

        // Mid-operation reset with a window of 200s.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) send(200, 0, 0, 1'b0);
        send(200, 1, 200, 1'b0);
        @(posedge clk);
        #1;
        done_in     = 1'b1;
        distance_in = 16'd200;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        done_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 7; i++) send(50, 0, 0, 1'b0);
        send(50, 1, 50, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("pending_expectations", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
